// File: rtl/gemm_array_ctrl.sv
// gemm_array_ctrl: sequencer for an NxN systolic GEMM array (clear, feed, drain, capture)
module gemm_array_ctrl #(
  parameter int N      = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   k_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              cfg_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [N-1:0]      skew_valid,
  output logic              array_clr,
  output logic              res_capture
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] FEED  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam int CW = $clog2(2 * N) + 1;
  logic [2:0] state, n_state;
  logic [ADDR_W-1:0] k_last;
  logic [CW-1:0] cnt;
  logic legal, go, abt, last_feed, last_drain;
  assign legal      = (k_len != '0) && (k_len <= ((ADDR_W + 1)'(1) << ADDR_W));
  assign go         = (state == IDLE) && start && legal;
  assign abt        = abort && (state != IDLE);
  assign last_feed  = (state == FEED) && (rd_addr == k_last);
  assign last_drain = (state == DRAIN) && (cnt == CW'(2 * N - 1));
  // next state: abort overrides every normal transition
  always_comb
    n_state = abt               ? IDLE  :
              go                ? CLEAR :
              (state == CLEAR)  ? FEED  :
              last_feed         ? DRAIN :
              last_drain        ? DONE  :
              (state == DONE)   ? IDLE  : state;
  // state, counters and registered outputs derived from the next state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      k_last      <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cfg_err     <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      skew_valid  <= '0;
      array_clr   <= 1'b1;
      res_capture <= 1'b0;
    end else begin
      state       <= n_state;
      if (go) k_last <= ADDR_W'(k_len - 1'b1);
      cnt         <= (state == DRAIN) ? cnt + 1'b1 : '0;
      busy        <= n_state != IDLE;
      done        <= n_state == DONE;
      aborted     <= abt;
      cfg_err     <= (state == IDLE) && start && !legal;
      rd_en       <= n_state == FEED;
      rd_addr     <= (state == FEED && n_state == FEED) ? rd_addr + 1'b1 : '0;
      skew_valid  <= abt ? '0 : (skew_valid << 1) | N'(rd_en);
      array_clr   <= (n_state == CLEAR) || abt;
      res_capture <= !abt && (state == DRAIN) && (cnt == CW'(2 * N - 2));
    end
endmodule
